// File: rtl/parking_sensor_emulator.sv
`default_nettype none
// =============================================================================
// parking_sensor_emulator : drives timed S1/S2 waveforms for one parking-gate
// manoeuvre per command; PARKING_EMU_SHADOW_COUNT_EN adds a shadow occupancy count.
// Revision: 1.0
// =============================================================================
module parking_sensor_emulator #(
  parameter int PHASE_CYCLES = 1000,
  parameter int GAP_CYCLES   = 1000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       S1,
  output logic       S2,
  output logic       busy,
  output logic       done,
  output logic [6:0] expected_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P1   = 3'd1;
  localparam logic [2:0] ST_P2   = 3'd2;
  localparam logic [2:0] ST_P3   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic [1:0] OP_ENTER       = 2'b00;
  localparam logic [1:0] OP_EXIT        = 2'b01;
  localparam logic [1:0] OP_ABORT_ENTER = 2'b10;
  localparam logic [1:0] OP_ABORT_EXIT  = 2'b11;

  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       op_q, op_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             timer_expired;

  assign cmd_ready     = (state_q == ST_IDLE) && !btnC;
  assign accept        = cmd_valid && cmd_ready;
  assign timer_expired = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      op_q    <= OP_ENTER;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_P1;
          timer_d = PHASE_LOAD;
          op_d    = cmd_op;
        end
      end
      ST_P1: begin
        if (!timer_expired) begin
          timer_d = timer_q - TIMER_ONE;
        end else if (op_q[1]) begin
          // Aborts only ever touch one line, so they go straight to the gap.
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end else begin
          state_d = ST_P2;
          timer_d = PHASE_LOAD;
        end
      end
      ST_P2: begin
        if (!timer_expired) begin
          timer_d = timer_q - TIMER_ONE;
        end else begin
          state_d = ST_P3;
          timer_d = PHASE_LOAD;
        end
      end
      ST_P3: begin
        if (!timer_expired) begin
          timer_d = timer_q - TIMER_ONE;
        end else begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (!timer_expired) begin
          timer_d = timer_q - TIMER_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered lines track the state.
  always_comb begin
    s1_d   = 1'b0;
    s2_d   = 1'b0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
        done_d = (state_q == ST_GAP);
      end
      ST_P1: begin
        s1_d = (op_d == OP_ENTER) || (op_d == OP_ABORT_ENTER);
        s2_d = (op_d == OP_EXIT)  || (op_d == OP_ABORT_EXIT);
      end
      ST_P2: begin
        s1_d = 1'b1;
        s2_d = 1'b1;
      end
      ST_P3: begin
        s1_d = (op_d == OP_EXIT);
        s2_d = (op_d == OP_ENTER);
      end
      default: begin
        s1_d = 1'b0;
        s2_d = 1'b0;
      end
    endcase
  end

  assign S1   = s1_q;
  assign S2   = s2_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef PARKING_EMU_SHADOW_COUNT_EN
  logic [6:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == ST_P3) && (state_d == ST_GAP)) begin
      if ((op_q == OP_ENTER) && (count_q != 7'd99)) begin
        count_d = count_q + 7'd1;
      end else if ((op_q == OP_EXIT) && (count_q != 7'd0)) begin
        count_d = count_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expected_count = count_q;
`else
  assign expected_count = 7'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parking_sensor_emulator.sv
`default_nettype none
// =============================================================================
// tb_parking_sensor_emulator : directed + random stimulus against a timeline model.
// Revision: 1.0
// =============================================================================
module tb_parking_sensor_emulator;

  localparam int P = 4;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       btnC = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready;
  logic       S1;
  logic       S2;
  logic       busy;
  logic       done;
  logic [6:0] expected_count;

  always #5 clk = ~clk;

  parking_sensor_emulator #(
    .PHASE_CYCLES(P),
    .GAP_CYCLES  (G),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .btnC          (btnC),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_ready     (cmd_ready),
    .S1            (S1),
    .S2            (S2),
    .busy          (busy),
    .done          (done),
    .expected_count(expected_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a manoeuvre is the edge it was accepted on plus its op; every output
  // is a function of the number of edges elapsed since then.
  bit         m_active = 1'b0;
  int         m_acc_edge = 0;
  logic [1:0] m_op = 2'b00;
  int         m_count = 0;
  int         edge_no = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic int total_len(input logic [1:0] op);
    return (op[1] ? P : 3 * P) + G;
  endfunction

  function automatic bit model_idle();
    return !m_active || ((edge_no - m_acc_edge) >= total_len(m_op));
  endfunction

  task automatic step(input bit v, input logic [1:0] op, input bit rst);
    int k;
    bit acc;
    bit e1, e2, eb, ed;
    int ecnt;
    btnC      = rst;
    cmd_valid = v;
    cmd_op    = op;
    #1;
    check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, model_idle() && !rst});
    acc = model_idle() && !rst && v;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      m_active = 1'b0;
      m_count  = 0;
    end else if (acc) begin
      m_active   = 1'b1;
      m_acc_edge = edge_no;
      m_op       = op;
    end
    #1;
    e1 = 1'b0; e2 = 1'b0; eb = 1'b0; ed = 1'b0;
    if (m_active) begin
      k  = edge_no - m_acc_edge;
      eb = (k < total_len(m_op));
      ed = (k == total_len(m_op));
      case (m_op)
        2'b00: begin e1 = (k < 2 * P); e2 = (k >= P) && (k < 3 * P); end
        2'b01: begin e2 = (k < 2 * P); e1 = (k >= P) && (k < 3 * P); end
        2'b10: e1 = (k < P);
        default: e2 = (k < P);
      endcase
      if ((k == 3 * P) && !m_op[1]) begin
        if (m_op == 2'b00 && m_count < 99) m_count++;
        else if (m_op == 2'b01 && m_count > 0) m_count--;
      end
    end
`ifdef PARKING_EMU_SHADOW_COUNT_EN
    ecnt = m_count;
`else
    ecnt = 0;
`endif
    check_eq("S1", {31'd0, S1}, {31'd0, e1});
    check_eq("S2", {31'd0, S2}, {31'd0, e2});
    check_eq("busy", {31'd0, busy}, {31'd0, eb});
    check_eq("done", {31'd0, done}, {31'd0, ed});
    check_eq("expected_count", {25'd0, expected_count}, ecnt);
  endtask

  initial begin
    repeat (2) step(1'b0, 2'b00, 1'b1);
    repeat (3) step(1'b0, 2'b00, 1'b0);

    // Single enter, exit (from zero), and both aborts.
    step(1'b1, 2'b00, 1'b0);
    repeat (20) step(1'b0, 2'($urandom_range(3, 0)), 1'b0);
    step(1'b1, 2'b01, 1'b0);
    repeat (20) step(1'b0, 2'($urandom_range(3, 0)), 1'b0);
    step(1'b1, 2'b01, 1'b0);
    repeat (20) step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    repeat (12) step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    repeat (12) step(1'b0, 2'b00, 1'b0);

    // Back-to-back enters with valid held: count climbs to the ceiling and holds.
    repeat (100 * (3 * P + G + 1) + 5) step(1'b1, 2'b00, 1'b0);
    repeat (3 * (3 * P + G + 1)) step(1'b1, 2'b01, 1'b0);
    repeat (5) step(1'b0, 2'b00, 1'b0);

    // Reset six edges into an enter.
    step(1'b1, 2'b00, 1'b0);
    repeat (5) step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    repeat (20) step(1'b0, 2'b00, 1'b0);

    // Valid held while busy with alternating ops: only the latched op shows.
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 2 * (3 * P + G + 1); i++) step(1'b1, (i % 2 == 0) ? 2'b11 : 2'b01, 1'b0);
    repeat (20) step(1'b0, 2'b00, 1'b0);

    // Random traffic with occasional resets.
    repeat (3000) step(($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)), ($urandom_range(299, 0) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
